mul_shift_ctrl: RTL



---
 rtl/mul_shift_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mul_shift_ctrl.sv
// mul_shift_ctrl: sequencer for a shift-and-add multiplier that sits one
// stage downstream of an external left-shift register.
//
// Operation: on an accepted start the operands are latched. The multiplicand
// is written into the shift register through its save handshake. After that,
// the block repeats one ADD step per multiplier bit. Each step conditionally
// adds the register output into the accumulator and then asks the register
// for a left shift. The loop ends early once the remaining multiplier bits
// are all zero. The product is the low WIDTH bits of
// multiplicand*multiplier.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   start                    one-cycle request, accepted only in IDLE
//   multiplicand, multiplier operands, sampled on accepted start
//   busy                     high from the cycle after start through DONE
//   done                     one-cycle pulse, product valid from this cycle
//   product                  result, held until overwritten by the next DONE
//   save_req / save_fin      level handshake to the register save port
//   left_req / left_fin      level handshake to the register shift port
//   shreg_in                 data to the register (the latched multiplicand)
//   shreg_out                register contents, stable while a fin is high
module mul_shift_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             save_req,
  input  logic             save_fin,
  output logic             left_req,
  input  logic             left_fin,
  output logic [WIDTH-1:0] shreg_in,
  input  logic [WIDTH-1:0] shreg_out
);

  typedef enum logic [2:0] {
    IDLE, SAVE_REQ, SAVE_WAIT, ADD, LEFT_REQ, LEFT_WAIT, DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n, mplr, mplr_n, product_n, shreg_in_n;
  logic [WIDTH-1:0] acc_sum, mplr_sh;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             save_req_n, left_req_n;

  // The fin inputs are asynchronous. Bits [1:0] of each chain synchronize
  // the input. Bit [2] holds the previous synchronized value, so a rise is a
  // single-cycle pulse.
  logic [2:0] save_sync, left_sync;
  logic       save_rise, left_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      save_sync <= '0;
      left_sync <= '0;
    end else begin
      save_sync <= {save_sync[1:0], save_fin};
      left_sync <= {left_sync[1:0], left_fin};
    end
  end

  assign save_rise = save_sync[1] & ~save_sync[2];
  assign left_rise = left_sync[1] & ~left_sync[2];

  assign acc_sum = mplr[0] ? acc + shreg_out : acc;
  assign mplr_sh = mplr >> 1;
  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_n    = state;
    acc_n      = acc;
    mplr_n     = mplr;
    cnt_n      = cnt;
    product_n  = product;
    shreg_in_n = shreg_in;
    save_req_n = save_req;
    left_req_n = left_req;
    case (state)
      IDLE: if (start) begin
        shreg_in_n = multiplicand;
        mplr_n     = multiplier;
        acc_n      = '0;
        cnt_n      = '0;
        state_n    = SAVE_REQ;
      end
      SAVE_REQ: begin
        save_req_n = 1'b1;
        state_n    = SAVE_WAIT;
      end
      SAVE_WAIT: if (save_rise) begin
        save_req_n = 1'b0;
        state_n    = ADD;
      end
      ADD: begin
        acc_n  = acc_sum;
        mplr_n = mplr_sh;
        cnt_n  = cnt_inc;
        // Product is loaded on the way into DONE, so it is already valid
        // during the done pulse.
        if (cnt_inc == LAST || mplr_sh == '0) begin
          product_n = acc_sum;
          state_n   = DONE;
        end else begin
          state_n   = LEFT_REQ;
        end
      end
      LEFT_REQ: begin
        left_req_n = 1'b1;
        state_n    = LEFT_WAIT;
      end
      LEFT_WAIT: if (left_rise) begin
        left_req_n = 1'b0;
        state_n    = ADD;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      mplr     <= '0;
      cnt      <= '0;
      product  <= '0;
      shreg_in <= '0;
      save_req <= 1'b0;
      left_req <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      mplr     <= mplr_n;
      cnt      <= cnt_n;
      product  <= product_n;
      shreg_in <= shreg_in_n;
      save_req <= save_req_n;
      left_req <= left_req_n;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
